// File: rtl/sram_1rw1r_param_if.sv
// sram_1rw1r_param_if: bus bundle for the 1RW+1R memory
//   port 0 (rw): csb0, web0, wmask0, addr0, din0 -> dout0, dout0_valid
//   port 1 (r) : csb1, addr1 -> dout1, dout1_valid
//   status     : collision pulse, collision_cnt
interface sram_1rw1r_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int WMASK_WIDTH = 4
);
  logic csb0;
  logic web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic dout0_valid;
  logic csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic dout1_valid;
  logic collision;
  logic [15:0] collision_cnt;
  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input dout0, dout0_valid, dout1, dout1_valid, collision, collision_cnt
  );
  modport slave (
    input csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout0_valid, dout1, dout1_valid, collision, collision_cnt
  );
endinterface

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW+1R synchronous memory with read-valid flags and collision tracking
module sram_1rw1r_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int WMASK_WIDTH = 4,
  parameter int READ_LATENCY = 1,
  parameter bit BYPASS = 1'b1,
  parameter string INIT_FILE = ""
) (
  input logic clk,
  input logic rst_n,
  sram_1rw1r_param_if.slave bus
);
  localparam int LW = DATA_WIDTH / WMASK_WIDTH;
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic rd0, rd1, wr0, col;
  logic [DATA_WIDTH-1:0] bits, fwd;
  logic [READ_LATENCY:0] v0, v1, c1;
  logic [DATA_WIDTH-1:0] d0 [READ_LATENCY+1];
  logic [DATA_WIDTH-1:0] d1 [READ_LATENCY+1];
  logic [15:0] cnt_q;
  assign rd0 = !bus.csb0 && bus.web0;
  assign wr0 = !bus.csb0 && !bus.web0;
  assign rd1 = !bus.csb1;
  assign col = wr0 && |bus.wmask0 && rd1 && bus.addr0 == bus.addr1;
  always_comb begin
    bits = '0;
    for (int i = 0; i < WMASK_WIDTH; i++) bits[i*LW +: LW] = {LW{bus.wmask0[i]}};
  end
  assign fwd = (BYPASS && col) ? (bus.din0 & bits) | (mem[bus.addr1] & ~bits) : mem[bus.addr1];
  always_ff @(posedge clk)
    for (int i = 0; i < WMASK_WIDTH; i++)
      if (wr0 && bus.wmask0[i]) mem[bus.addr0][i*LW +: LW] <= bus.din0[i*LW +: LW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= '0;
      v1 <= '0;
      c1 <= '0;
      cnt_q <= '0;
      for (int j = 0; j <= READ_LATENCY; j++) begin
        d0[j] <= '0;
        d1[j] <= '0;
      end
    end else begin
      v0 <= {v0[READ_LATENCY-1:0], rd0};
      v1 <= {v1[READ_LATENCY-1:0], rd1};
      c1 <= {c1[READ_LATENCY-1:0], col};
      if (rd0) d0[0] <= mem[bus.addr0];
      if (rd1) d1[0] <= fwd;
      for (int j = 1; j <= READ_LATENCY; j++) begin
        if (v0[j-1]) d0[j] <= d0[j-1];
        if (v1[j-1]) d1[j] <= d1[j-1];
      end
      if (col && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  assign bus.dout0 = d0[READ_LATENCY];
  assign bus.dout1 = d1[READ_LATENCY];
  assign bus.dout0_valid = v0[READ_LATENCY];
  assign bus.dout1_valid = v1[READ_LATENCY];
  assign bus.collision = c1[READ_LATENCY];
  assign bus.collision_cnt = cnt_q;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: scoreboard bench over two configurations (latency 1 with bypass, latency 2 without)
module tb_sram_1rw1r_param;
  typedef struct {
    logic [31:0] d;
    logic c;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[4][$];
  logic [31:0] m [2][512];
  logic [15:0] cnt [2];
  sram_1rw1r_param_if i1 ();
  sram_1rw1r_param_if i2 ();
  sram_1rw1r_param #(.READ_LATENCY(1), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  sram_1rw1r_param #(.READ_LATENCY(2), .BYPASS(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endfunction
  function automatic void mon(int k, string n, logic v, logic [31:0] d, logic c);
    exp_t e;
    if (v) begin
      if (q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s spurious valid act=%h exp=none", n, d);
      end else begin
        e = q[k].pop_front();
        chk({n, "_data"}, d, e.d);
        chk({n, "_cycle"}, cyc, e.due);
        chk({n, "_coll"}, {31'd0, c}, {31'd0, e.c});
      end
    end else if (q[k].size() != 0 && q[k][0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL %s missing valid act=none exp=%h", n, q[k][0].d);
      e = q[k].pop_front();
    end
  endfunction
  always @(negedge clk)
    if (rst_n) begin
      mon(0, "p0_a", i1.dout0_valid, i1.dout0, 1'b0);
      mon(1, "p1_a", i1.dout1_valid, i1.dout1, i1.collision);
      mon(2, "p0_b", i2.dout0_valid, i2.dout0, 1'b0);
      mon(3, "p1_b", i2.dout1_valid, i2.dout1, i2.collision);
      if ((i1.collision && !i1.dout1_valid) || (i2.collision && !i2.dout1_valid)) begin
        checks++;
        errors++;
        $display("FAIL coll_align act=1 exp=0");
      end
    end
  task automatic idle_sig();
    i1.csb0 = 1'b1; i1.web0 = 1'b1; i1.wmask0 = 4'h0; i1.addr0 = '0; i1.din0 = '0; i1.csb1 = 1'b1; i1.addr1 = '0;
    i2.csb0 = 1'b1; i2.web0 = 1'b1; i2.wmask0 = 4'h0; i2.addr0 = '0; i2.din0 = '0; i2.csb1 = 1'b1; i2.addr1 = '0;
  endtask
  task automatic idle(int n);
    idle_sig();
    repeat (n) @(negedge clk);
  endtask
  task automatic op(int k, bit r0, bit w0, logic [3:0] wm, logic [8:0] a0, logic [31:0] din, bit r1, logic [8:0] a1);
    logic [31:0] bm, old0, old1;
    bit col;
    int lat;
    exp_t e;
    lat = (k != 0) ? 2 : 1;
    idle_sig();
    bm = {{8{wm[3]}}, {8{wm[2]}}, {8{wm[1]}}, {8{wm[0]}}};
    old0 = m[k][a0];
    old1 = m[k][a1];
    col = w0 && wm != 4'h0 && r1 && a0 == a1;
    if (k == 0) begin
      i1.csb0 = !(r0 || w0); i1.web0 = !w0; i1.wmask0 = wm; i1.addr0 = a0; i1.din0 = din; i1.csb1 = !r1; i1.addr1 = a1;
    end else begin
      i2.csb0 = !(r0 || w0); i2.web0 = !w0; i2.wmask0 = wm; i2.addr0 = a0; i2.din0 = din; i2.csb1 = !r1; i2.addr1 = a1;
    end
    if (r0) begin
      e = '{old0, 1'b0, cyc + 1 + lat};
      q[2*k].push_back(e);
    end
    if (r1) begin
      e = '{(col && k == 0) ? (din & bm) | (old1 & ~bm) : old1, col, cyc + 1 + lat};
      q[2*k+1].push_back(e);
    end
    if (w0) m[k][a0] = (din & bm) | (old0 & ~bm);
    if (col && cnt[k] != 16'hFFFF) cnt[k] = cnt[k] + 16'd1;
    @(negedge clk);
    chk((k != 0) ? "cnt_b" : "cnt_a", {16'd0, (k != 0) ? i2.collision_cnt : i1.collision_cnt}, {16'd0, cnt[k]});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    idle_sig();
    cnt = '{16'd0, 16'd0};
    repeat (3) @(negedge clk);
    chk("rst_dout0_a", i1.dout0, 32'd0);
    chk("rst_dout1_a", i1.dout1, 32'd0);
    chk("rst_dout0_b", i2.dout0, 32'd0);
    chk("rst_dout1_b", i2.dout1, 32'd0);
    chk("rst_flags", {26'd0, i1.dout0_valid, i1.dout1_valid, i1.collision, i2.dout0_valid, i2.dout1_valid, i2.collision}, 32'd0);
    chk("rst_cnt", {i1.collision_cnt, i2.collision_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 0, 1, 4'hF, 9'd3, 32'h11223344, 0, 9'd0);
    op(0, 0, 1, 4'hF, 9'd7, 32'h00000000, 0, 9'd0);
    op(0, 0, 1, 4'b0101, 9'd3, 32'hAABBCCDD, 0, 9'd0);
    op(0, 0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd3);
    op(0, 0, 1, 4'h0, 9'd3, 32'hFFFFFFFF, 0, 9'd0);
    op(0, 1, 0, 4'h0, 9'd3, 32'h0, 0, 9'd0);
    op(0, 0, 1, 4'hF, 9'd7, 32'hDEADBEEF, 1, 9'd7);
    op(0, 0, 1, 4'b0011, 9'd7, 32'h12345678, 1, 9'd7);
    op(0, 0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd7);
    op(0, 0, 1, 4'h0, 9'd7, 32'h0, 1, 9'd7);
    op(0, 0, 1, 4'hF, 9'd8, 32'h00000055, 1, 9'd7);
    op(1, 0, 1, 4'hF, 9'd7, 32'h00000000, 0, 9'd0);
    op(1, 0, 1, 4'hF, 9'd7, 32'hDEADBEEF, 1, 9'd7);
    op(1, 0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd7);
    for (int i = 0; i < 16; i++) op(1, 0, 1, 4'hF, 9'(i), (32'h01010101 * (i + 1)) ^ 32'hA5000000, 0, 9'd0);
    for (int i = 0; i < 16; i++) op(1, 1, 0, 4'h0, 9'(i), 32'h0, 1, 9'(15 - i));
    idle(4);
    chk("hold_dout0_b", i2.dout0, m[1][15]);
    chk("hold_dout1_b", i2.dout1, m[1][0]);
    i2.csb0 = 1'b0; i2.web0 = 1'b1; i2.addr0 = 9'd5;
    @(negedge clk);
    idle_sig();
    rst_n = 1'b0;
    cnt = '{16'd0, 16'd0};
    @(negedge clk);
    chk("mid_rst_dout0_b", i2.dout0, 32'd0);
    chk("mid_rst_cnt_a", {16'd0, i1.collision_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_dout0_b", i2.dout0, 32'd0);
    op(1, 1, 0, 4'h0, 9'd5, 32'h0, 0, 9'd0);
    idle(3);
    force dut1.cnt_q = 16'hFFFE;
    #1;
    release dut1.cnt_q;
    cnt[0] = 16'hFFFE;
    op(0, 0, 1, 4'hF, 9'd9, 32'h01020304, 1, 9'd9);
    op(0, 0, 1, 4'hF, 9'd9, 32'h05060708, 1, 9'd9);
    op(0, 0, 1, 4'b1000, 9'd9, 32'hF0000000, 1, 9'd9);
    idle(5);
    for (int k = 0; k < 4; k++) chk("q_empty", q[k].size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
